bus_gate_arbiter: RTL and testbench
===================================

# bus_gate_arbiter

Sequencer for the shared 16-bit CPU bus gates. Four bus sources (MDR, ALU, PC, MARMUX) raise requests; the block grants ownership to at most one source at a time via one-hot gate enables that drive the bus mux gate inputs. It inserts a one-cycle dead (turnaround) cycle between owners, uses round-robin fairness, and optionally preempts owners that overstay a hold limit.

## Interface
Parameters:
- MAX_HOLD, 8, max consecutive owned cycles before preemption when another source is pending; legal 1..255.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  4  bus requests; bit0 MDR, bit1 ALU, bit2 PC, bit3 MARMUX; a source holds its bit high for as long as it wants the bus.
- gateMDR, gateALU, gatePC, gateMARMUX  out  1 each  registered gate enables; at most one high in any cycle.
- owner  out  2  index of current owner; valid only while bus_busy = 1, else 0.
- bus_busy  out  1  high while the FSM is in OWN.
- preempt  out  1  one-cycle pulse when an owner is forced off by MAX_HOLD.

Clock is Clk; reset is asynchronous and active-low (Reset_n).

## Operation
- FSM states: IDLE, OWN, TURN. Reset state IDLE.
- Round-robin pointer rr_last (2 bits, reset 3): the search order starts at rr_last+1 mod 4, so MDR wins first after reset.
- IDLE: if any req bit is set, choose the winner by round-robin, load owner, set rr_last = winner, clear hold_cnt, go to OWN. Otherwise stay in IDLE.
- OWN: the gate for owner is high. hold_cnt (width $clog2(MAX_HOLD+1)) increments each cycle and saturates at MAX_HOLD.
  - If req[owner] = 0, go to TURN.
  - Preemption (macro-dependent): if hold_cnt = MAX_HOLD and any other req bit is set, pulse preempt and go to TURN, even if req[owner] is still high.
  - Otherwise stay in OWN.
- TURN: all gates low for exactly one cycle. Arbitrate on the current req using the round-robin pointer, which already excludes the previous owner as first choice. If any req is set, go to OWN with the new winner; otherwise go to IDLE. A preempted owner that still requests competes normally and wins again only if it is the sole requester.
- Simultaneous requests are resolved only by round-robin order; no source has fixed priority.
- A request that drops in the same cycle it would be granted is still granted for one cycle. The source must tolerate this.
- Reset mid-operation: all gates, bus_busy and preempt fall immediately (asynchronously); owner = 0, rr_last = 3, hold_cnt = 0, state IDLE.

## Timing
- Reset values: all gate outputs 0, owner 0, bus_busy 0, preempt 0.
- Grant latency from IDLE: req sampled high at edge N gives gate high after edge N (visible in cycle N+1).
- Release: req[owner] sampled low at edge M gives gate low in cycle M+1 (TURN). The next owner's gate is high in cycle M+2 at the earliest.
- Bus dead time between different or repeated owners is always exactly 1 cycle. There is no dead time before the first grant out of IDLE.
- Preemption: hold_cnt reaches MAX_HOLD after MAX_HOLD owned cycles. The owner's gate is high for MAX_HOLD+1 cycles before TURN when a competitor is waiting. preempt is high during the first TURN cycle.
- All outputs are registered; there is no combinational path from req to any output.

## Configuration
- BUS_ARB_PREEMPT_EN defined: MAX_HOLD preemption is active as described above.
- Not defined: the owner keeps the bus until it drops req, regardless of competitors; preempt is tied to 0; hold_cnt logic is removed; MAX_HOLD is ignored.

## Test plan
- Reset, then req = 4'b0000 for 5 cycles: all gates stay 0, bus_busy = 0, state IDLE.
- req = 4'b1111 from cycle 1, each source dropping its req after 2 owned cycles: grant order MDR, ALU, PC, MARMUX, with exactly one all-low cycle between owners.
- PC (req = 4'b0100) alone held for 20 cycles with preemption enabled: gatePC stays high continuously and preempt never fires.
- With BUS_ARB_PREEMPT_EN and MAX_HOLD = 4: ALU owns; MDR requests at owned cycle 2. ALU gate is high for 5 cycles, preempt pulses once, one dead cycle follows, then gateMDR goes high.
- Same stimulus with the macro undefined: ALU holds until its req drops; preempt stays 0.
- Reset_n asserted low mid-OWN while gateMARMUX = 1: gate falls without a clock edge. After release, req = 4'b1001 grants MDR first.

Source files
------------

// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter
//   Sequencer for the shared 16-bit CPU bus gates. Four sources (MDR, ALU,
//   PC, MARMUX) request the bus. At most one is granted at a time through
//   one-hot registered gate enables. Ownership is round-robin and there is
//   exactly one dead (turnaround) cycle between consecutive owners.
//
//   Optional feature, macro BUS_ARB_PREEMPT_EN: an owner that has held the
//   bus for MAX_HOLD cycles is forced off when another source is pending.
//   Without the macro, MAX_HOLD is ignored and preempt is tied low.
//
// Parameters
//   MAX_HOLD    owned cycles before preemption can trigger (1..255)
// Ports
//   Clk         rising-edge clock
//   Reset_n     asynchronous active-low reset
//   req[3:0]    requests: bit0 MDR, bit1 ALU, bit2 PC, bit3 MARMUX
//   gateMDR, gateALU, gatePC, gateMARMUX   registered one-hot gate enables
//   owner[1:0]  current owner index while bus_busy, else 0
//   bus_busy    high while a source owns the bus
//   preempt     one-cycle pulse in the turnaround after a forced release
module bus_gate_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] req,
  output logic       gateMDR,
  output logic       gateALU,
  output logic       gatePC,
  output logic       gateMARMUX,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       preempt
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_gate_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] rr_last_q, rr_last_d;
  logic [3:0] gate_q, gate_d;
  logic       busy_q, busy_d;

  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       preempt_hit;

  // Round-robin search starting one past the last winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = rr_last_q + 2'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

`ifdef BUS_ARB_PREEMPT_EN
  localparam int unsigned    HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    owner_mask;
  logic          preempt_q;

  assign owner_mask  = 4'b0001 << owner_q;
  // Only a still-requesting owner is forced off; a voluntary drop wins.
  assign preempt_hit = (state_q == OWN) && req[owner_q] &&
                       (hold_q == HOLD_MAX) && (|(req & ~owner_mask));

  // Counter is held at zero outside OWN, so every tenure starts from 0.
  always_comb begin
    hold_d = hold_q;
    if (state_q != OWN) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_hit;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt_hit = 1'b0;
  assign preempt     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE, TURN: begin
        owner_d = '0;
        if (grant_valid) begin
          state_d   = OWN;
          owner_d   = grant_idx;
          rr_last_d = grant_idx;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!req[owner_q] || preempt_hit) begin
          state_d = TURN;
          owner_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  // Gates and busy are registered from next state so outputs come straight
  // off flops.
  always_comb begin
    busy_d = (state_d == OWN);
    gate_d = busy_d ? (4'b0001 << owner_d) : 4'b0000;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_last_q <= 2'd3;
      gate_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
    end
  end

  assign gateMDR    = gate_q[0];
  assign gateALU    = gate_q[1];
  assign gatePC     = gate_q[2];
  assign gateMARMUX = gate_q[3];
  assign owner      = owner_q;
  assign bus_busy   = busy_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Testbench for bus_gate_arbiter: scoreboard of expected per-cycle outputs
// produced by a tenure-level reference model, plus directed scenarios.
module tb_bus_gate_arbiter;

  localparam int unsigned MAX_HOLD = 4;
`ifdef BUS_ARB_PREEMPT_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [3:0] req;
  logic       gateMDR, gateALU, gatePC, gateMARMUX;
  logic [1:0] owner;
  logic       bus_busy, preempt;
  logic [3:0] gv;

  assign gv = {gateMARMUX, gatePC, gateALU, gateMDR};

  bus_gate_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req        (req),
    .gateMDR    (gateMDR),
    .gateALU    (gateALU),
    .gatePC     (gatePC),
    .gateMARMUX (gateMARMUX),
    .owner      (owner),
    .bus_busy   (bus_busy),
    .preempt    (preempt)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  gates;
    logic [1:0]  own;
    logic        busy;
    logic        pre;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the bus, for how many cycles so far, and who
  // won last. -1 means nobody owns the bus this cycle.
  int m_own  = -1;
  int m_held = 0;
  int m_last = 3;
  bit m_pre  = 1'b0;

  task automatic model_reset();
    m_own  = -1;
    m_held = 0;
    m_last = 3;
    m_pre  = 1'b0;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model across one clock edge at which r is sampled.
  task automatic model_step(input logic [3:0] r);
    int w;
    m_pre = 1'b0;
    if (m_own >= 0) begin
      m_held++;
      if (!r[m_own]) begin
        m_own = -1;
      end else if (PRE_EN && m_held > int'(MAX_HOLD) &&
                   (r & ~(4'b0001 << m_own)) != 4'b0000) begin
        m_own = -1;
        m_pre = 1'b1;
      end
    end else begin
      w = rr_pick(r, m_last);
      if (w >= 0) begin
        m_own  = w;
        m_last = w;
        m_held = 0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r);
    e.cyc   = cyc + 1;
    e.gates = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    e.own   = (m_own >= 0) ? 2'(m_own) : 2'd0;
    e.busy  = (m_own >= 0);
    e.pre   = m_pre;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic [3:0] r);
    @(posedge Clk);
    #1;
    drive(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every scheduled cycle and gathers simple statistics.
  int         cnt_alu = 0;
  int         cnt_pc  = 0;
  int         cnt_pre = 0;
  int         grant_log[$];
  logic [3:0] prev_gv = 4'b0000;

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || gv !== e.gates || owner !== e.own ||
            bus_busy !== e.busy || preempt !== e.pre) begin
          errors++;
          $display("FAIL cycle %0d (exp for %0d): gates=%b owner=%0d busy=%b preempt=%b, expected gates=%b owner=%0d busy=%b preempt=%b",
                   cyc, e.cyc, gv, owner, bus_busy, preempt,
                   e.gates, e.own, e.busy, e.pre);
        end
      end
      if (Reset_n) begin
        cnt_alu += int'(gateALU);
        cnt_pc  += int'(gatePC);
        cnt_pre += int'(preempt);
        for (int i = 0; i < 4; i++) begin
          if (gv[i] && !prev_gv[i]) grant_log.push_back(i);
        end
      end
      prev_gv = gv;
    end
  end

  logic [3:0]  done;
  int          held[4];
  logic [3:0]  rr;
  int unsigned left[4];
  bit          seen;

  initial begin
    req     = 4'b0000;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #3 Reset_n = 1'b1;
    chk("reset_gates", int'(gv), 0);
    chk("reset_owner", int'(owner), 0);
    chk("reset_busy", int'(bus_busy), 0);
    chk("reset_preempt", int'(preempt), 0);

    // Idle with no requests.
    repeat (5) cycle(4'b0000);

    // All four request; each drops in its second owned cycle.
    grant_log.delete();
    done = 4'b0000;
    for (int i = 0; i < 4; i++) held[i] = 0;
    for (int n = 0; n < 60 && done != 4'hF; n++) begin
      @(posedge Clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (gv[i]) begin
          held[i]++;
          if (held[i] >= 2) done[i] = 1'b1;
        end
      end
      drive(~done);
    end
    chk("rr_all_served", int'(done), 15);
    repeat (3) cycle(4'b0000);
    chk("rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) begin
      chk($sformatf("rr_order_%0d", i), grant_log[i], i);
    end

    // PC alone for 20 cycles keeps the bus without preemption.
    cnt_pc  = 0;
    cnt_pre = 0;
    repeat (20) cycle(4'b0100);
    repeat (3) cycle(4'b0000);
    chk("pc_hold_cycles", cnt_pc, 20);
    chk("pc_no_preempt", cnt_pre, 0);

    // ALU owns; MDR joins in ALU's second owned cycle; ALU gives up its
    // request shortly after MDR would have taken over.
    cnt_alu = 0;
    cnt_pre = 0;
    repeat (2) cycle(4'b0010);
    repeat (4) cycle(4'b0011);
    repeat (6) cycle(4'b0001);
    repeat (4) cycle(4'b0000);
    chk("alu_gate_cycles", cnt_alu, PRE_EN ? int'(MAX_HOLD) + 1 : 6);
    chk("preempt_pulses", cnt_pre, PRE_EN ? 1 : 0);

    // Asynchronous reset while MARMUX owns the bus.
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      cycle(4'b1000);
      seen = gateMARMUX;
    end
    chk("marmux_granted", int'(seen), 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("async_gate_low", int'(gv), 0);
    chk("async_busy_low", int'(bus_busy), 0);
    chk("async_preempt_low", int'(preempt), 0);
    chk("async_owner_zero", int'(owner), 0);
    sb.delete();
    model_reset();
    req = 4'b0000;
    repeat (2) @(posedge Clk);
    #3 Reset_n = 1'b1;
    grant_log.delete();
    repeat (4) cycle(4'b1001);
    repeat (4) cycle(4'b0000);
    chk("post_reset_first_grant",
        (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Randomized requests: each source holds a random level for a random
    // number of cycles.
    rr = 4'b0000;
    for (int i = 0; i < 4; i++) left[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (left[i] == 0) begin
          rr[i]   = ($urandom_range(0, 2) != 0);
          left[i] = $urandom_range(1, 14);
        end else begin
          left[i]--;
        end
      end
      cycle(rr);
    end
    repeat (3) cycle(4'b0000);

    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge Clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
